// File: rtl/cfu_mac_seq_pkg.sv
// Shared opcodes, FSM states and datapath widths for the CFU MAC sequencer.
// MAC_SEQ_OFFSET_EN widens the per-slice sum to hold offset-adjusted lanes.
package mac_seq_pkg;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_ACC_W      = 32;

  localparam logic [2:0] PUSH       = 3'd0;
  localparam logic [2:0] DRAIN      = 3'd1;
  localparam logic [2:0] CLEAR      = 3'd2;
  localparam logic [2:0] SET_OFFSET = 3'd3;

  // Lanes are carried 10 bits wide so a signed byte plus a 9-bit offset never wraps.
  localparam int LANE_W = 10;
`ifdef MAC_SEQ_OFFSET_EN
  // Offset-adjusted lanes reach |384| * 3 * 4 = 4608, one bit beyond 13-bit signed.
  localparam int SUM_W = 14;
`else
  localparam int SUM_W = 13;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cfu_mac_seq_if.sv
// CFU command/response handshake bundle; master is the CPU side, slave the CFU.
interface cfu_mac_seq_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0
  );

endinterface

// File: rtl/cfu_mac_seq_dot4_slice.sv
// dot4_slice: combinational sum over 4 lanes of (signed A lane x 2-bit B slice);
// the top slice of each B byte is its sign-bearing pair, so msb_slice treats it as -2..1.
module dot4_slice
  import mac_seq_pkg::*;
(
  input  logic [4*LANE_W-1:0]     a_lanes,
  input  logic [7:0]              b_bits,
  input  logic                    msb_slice,
  output logic signed [SUM_W-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      logic signed [LANE_W-1:0] a_i;
      logic signed [2:0]        s_i;
      a_i = a_lanes[i*LANE_W +: LANE_W];
      s_i = {msb_slice & b_bits[2*i+1], b_bits[2*i +: 2]};
      sum = sum + SUM_W'(a_i) * SUM_W'(s_i);
    end
  end

endmodule

// File: rtl/cfu_mac_seq.sv
// cfu_mac_seq: CFU sequencer that queues operand pairs and drains them through a
// 4-cycle bit-serial dot-product engine into an accumulator. Option: MAC_SEQ_OFFSET_EN.
module cfu_mac_seq
  import mac_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ACC_W      = DEF_ACC_W
) (
  input logic          clk,
  input logic          reset,
  cfu_mac_seq_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t state, state_next;

  logic [2:0] funct3;
  logic       funct7_zero;
  logic       is_push;
  logic       cmd_ready;
  logic       rsp_valid;
  logic       cmd_fire;

  logic [63:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             fifo_full, fifo_empty;
  logic             push, pop;

  logic                    busy;
  logic [1:0]              slice_idx;
  logic [31:0]             a_reg, b_reg;
  logic [4*LANE_W-1:0]     a_lanes;
  logic [7:0]              b_bits;
  logic signed [LANE_W-1:0] lane_offset;
  logic signed [SUM_W-1:0] slice_sum;
  logic signed [ACC_W-1:0] sum_ext, slice_term;
  logic signed [ACC_W-1:0] acc;

  logic        drained;
  logic        wait_clear;
  logic        clear_now;
  logic [31:0] rsp_data;
  logic [31:0] offset_rsp;

  assign funct3      = bus.cmd_payload_function_id[2:0];
  assign funct7_zero = (bus.cmd_payload_function_id[9:3] == 7'd0);
  assign is_push     = funct7_zero && (funct3 == PUSH);
  assign cmd_fire    = bus.cmd_valid && cmd_ready;
  assign drained     = fifo_empty && !busy;
  assign clear_now   = (state == WAIT) && drained && wait_clear;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    // NOTE: registers update with <= so every flop samples pre-edge values; = here would create order-dependent races.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: if (cmd_fire) begin
        if (funct7_zero && (funct3 == DRAIN || funct3 == CLEAR)) state_next = WAIT;
        else                                                     state_next = RESP;
      end
      WAIT:    if (drained) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (state == RESP);
    cmd_ready = (state == IDLE) && !rsp_valid && !(fifo_full && is_push);
  end

  assign bus.cmd_ready             = cmd_ready;
  assign bus.rsp_valid             = rsp_valid;
  assign bus.rsp_payload_outputs_0 = rsp_data;

  // ---------------------------------------------------------------- FIFO
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = cmd_fire && is_push;
  assign pop        = !fifo_empty && (!busy || slice_idx == 2'd3);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // NOTE: storage is not reset; count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_payload_inputs_0, bus.cmd_payload_inputs_1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // ---------------------------------------------------------------- Offset
`ifdef MAC_SEQ_OFFSET_EN
  logic signed [8:0] offset;

  always_ff @(posedge clk) begin
    if (reset)
      offset <= '0;
    else if (cmd_fire && funct7_zero && funct3 == SET_OFFSET)
      offset <= bus.cmd_payload_inputs_0[8:0];
  end

  assign offset_rsp  = 32'(offset);
  assign lane_offset = LANE_W'(offset);
`else
  assign offset_rsp  = '0;
  assign lane_offset = '0;
`endif

  // ---------------------------------------------------------------- Engine
  // Popping on the final slice edge lets the next pair start without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      slice_idx <= '0;
    end else if (pop) begin
      busy      <= 1'b1;
      slice_idx <= '0;
      a_reg     <= mem[rd_ptr][63:32];
      b_reg     <= mem[rd_ptr][31:0];
    end else if (busy) begin
      slice_idx <= slice_idx + 1'b1;
      if (slice_idx == 2'd3) busy <= 1'b0;
    end
  end

  always_comb begin
    a_lanes = '0;
    b_bits  = '0;
    for (int i = 0; i < 4; i++) begin
      a_lanes[i*LANE_W +: LANE_W] = LANE_W'($signed(a_reg[8*i +: 8])) + lane_offset;
      b_bits[2*i +: 2]            = b_reg[8*i + 2*int'(slice_idx) +: 2];
    end
  end

  dot4_slice u_dot4_slice (
    .a_lanes   (a_lanes),
    .b_bits    (b_bits),
    .msb_slice (slice_idx == 2'd3),
    .sum       (slice_sum)
  );

  assign sum_ext    = ACC_W'(slice_sum);
  assign slice_term = sum_ext << {slice_idx, 1'b0};

  always_ff @(posedge clk) begin
    if (reset)          acc <= '0;
    else if (clear_now) acc <= '0;
    else if (busy)      acc <= acc + slice_term;
  end

  // ---------------------------------------------------------------- Response
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data   <= '0;
      wait_clear <= 1'b0;
    end else if (cmd_fire) begin
      wait_clear <= funct7_zero && (funct3 == CLEAR);
      if (is_push)                                    rsp_data <= 32'(count_next);
      else if (funct7_zero && funct3 == SET_OFFSET)   rsp_data <= offset_rsp;
      else                                            rsp_data <= '0;
    end else if (state == WAIT && drained) begin
      rsp_data <= 32'(acc);
    end
  end

endmodule

// File: tb/tb_cfu_mac_seq.sv
// Self-checking bench for cfu_mac_seq: directed vectors plus randomized command
// rounds scored against a plain-arithmetic dot-product model.
`timescale 1ns/1ps
module tb_cfu_mac_seq;
  import mac_seq_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cfu_mac_seq_if bus ();

  cfu_mac_seq #(.FIFO_DEPTH(DEPTH), .ACC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests   = 0;
  int n_fail    = 0;
  int acc_model = 0;
  int off_model = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int dot(input logic [31:0] a, input logic [31:0] b, input int off);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      byte ai;
      byte bi;
      ai = a[8*i +: 8];
      bi = b[8*i +: 8];
      s += (int'(ai) + off) * int'(bi);
    end
    return s;
  endfunction

  // One full command/response transaction; starts and ends 1ns after a rising edge.
  task automatic issue(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1,
                       input string tag, output logic [31:0] rsp, output int stall);
    int cyc = 0;
    stall = 0;
    rsp   = '0;
    bus.cmd_payload_function_id = fid;
    bus.cmd_payload_inputs_0    = in0;
    bus.cmd_payload_inputs_1    = in1;
    bus.cmd_valid               = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && stall < 200) begin
      stall++;
      @(negedge clk);
    end
    if (!bus.cmd_ready) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    while (!bus.rsp_valid && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
    if (!bus.rsp_valid) begin
      check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
      return;
    end
    rsp = bus.rsp_payload_outputs_0;
    @(posedge clk);
    #1;
  endtask

  // Issues a command, checks its response against the model and updates the model.
  task automatic do_cmd(input string tag, input logic [9:0] fid, input logic [31:0] in0,
                        input logic [31:0] in1, output logic [31:0] rsp, output int stall);
    issue(fid, in0, in1, tag, rsp, stall);
    if (fid[9:3] != 7'd0) begin
      check(tag, rsp, 32'd0);
    end else begin
      case (fid[2:0])
        PUSH: begin
          check(tag, 32'(rsp >= 1 && rsp <= DEPTH), 32'd1);
          acc_model += dot(in0, in1, off_model);
        end
        DRAIN: check(tag, rsp, acc_model);
        CLEAR: begin
          check(tag, rsp, acc_model);
          acc_model = 0;
        end
        SET_OFFSET: begin
`ifdef MAC_SEQ_OFFSET_EN
          check(tag, rsp, off_model);
          off_model = $signed(in0[8:0]);
`else
          check(tag, rsp, 32'd0);
`endif
        end
        default: check(tag, rsp, 32'd0);
      endcase
    end
  endtask

  initial begin
    logic [31:0] r;
    int st;
    int max_occ, stall_tot, bad_stall, prev;

    reset                       = 1'b1;
    bus.cmd_valid               = 1'b0;
    bus.cmd_payload_function_id = '0;
    bus.cmd_payload_inputs_0    = '0;
    bus.cmd_payload_inputs_1    = '0;
    bus.rsp_ready               = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", bus.rsp_payload_outputs_0, 32'd0);
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic single pair.
    do_cmd("push1", 10'd0, 32'h01020304, 32'h01010101, r, st);
    check("push1_occ", r, 32'd1);
    do_cmd("drain1", 10'd1, '0, '0, r, st);
    check("drain1_val", r, 32'h0000000A);
    do_cmd("clear1", 10'd2, '0, '0, r, st);

    // Most negative A against signed-slice B.
    do_cmd("push2", 10'd0, 32'h80808080, 32'h7F7F7F7F, r, st);
    do_cmd("drain2", 10'd1, '0, '0, r, st);
    check("drain2_val", r, 32'hFFFF0200);
    do_cmd("clear2", 10'd2, '0, '0, r, st);

    // Back-to-back pushes outrun the engine until the FIFO fills.
    max_occ = 0; stall_tot = 0; bad_stall = 0; prev = 0;
    for (int i = 0; i < 24; i++) begin
      do_cmd("fill_push", 10'd0, 32'h01010101, 32'h02020202, r, st);
      if (st > 0) begin
        stall_tot += st;
        if (prev != DEPTH) bad_stall++;
      end
      if (int'(r) > max_occ) max_occ = int'(r);
      prev = int'(r);
    end
    check("fill_max_occ", 32'(max_occ), 32'(DEPTH));
    check("fill_stalled", 32'(stall_tot > 0), 32'd1);
    check("fill_stall_only_when_full", 32'(bad_stall), 32'd0);
    do_cmd("fill_drain", 10'd1, '0, '0, r, st);
    check("fill_drain_val", r, 32'd192);
    do_cmd("fill_clear", 10'd2, '0, '0, r, st);
    check("fill_clear_val", r, 32'd192);
    do_cmd("post_clear_drain", 10'd1, '0, '0, r, st);

    // Non-zero funct7 is a no-op.
    do_cmd("f7_nop", 10'h008, 32'h01010101, 32'h01010101, r, st);
    do_cmd("f7_drain", 10'd1, '0, '0, r, st);
    do_cmd("f7_push", 10'd0, 32'h01010101, 32'h01010101, r, st);
    check("f7_fifo_empty", r, 32'd1);
    do_cmd("f7_drain2", 10'd1, '0, '0, r, st);
    do_cmd("f7_clear", 10'd2, '0, '0, r, st);

    // Offset (or its absence in the default build).
    do_cmd("set_off128", 10'd3, 32'd128, '0, r, st);
    do_cmd("off_push", 10'd0, 32'hFFFFFFFF, 32'h01010101, r, st);
    do_cmd("off_drain", 10'd1, '0, '0, r, st);
`ifdef MAC_SEQ_OFFSET_EN
    check("off_drain_val", r, 32'd508);
`else
    check("off_drain_val", r, 32'hFFFFFFFC);
`endif
    do_cmd("set_off0", 10'd3, 32'd0, '0, r, st);
    do_cmd("off_clear", 10'd2, '0, '0, r, st);

    // Randomized rounds of mixed commands, each closed by DRAIN or CLEAR.
    for (int rd = 0; rd < 8; rd++) begin
      int n = $urandom_range(3, 10);
      if (rd % 2 == 0) do_cmd("rnd_set_off", 10'd3, $urandom(), '0, r, st);
      for (int k = 0; k < n; k++) begin
        int kind = $urandom_range(0, 9);
        if (kind == 0)
          do_cmd("rnd_unsup", {7'd0, 3'($urandom_range(4, 7))}, $urandom(), $urandom(), r, st);
        else if (kind == 1)
          do_cmd("rnd_f7", {7'($urandom_range(1, 127)), 3'($urandom_range(0, 7))},
                 $urandom(), $urandom(), r, st);
        else
          do_cmd("rnd_push", 10'd0, $urandom(), $urandom(), r, st);
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
      end
      if (rd % 2 == 0) do_cmd("rnd_drain", 10'd1, '0, '0, r, st);
      else             do_cmd("rnd_clear", 10'd2, '0, '0, r, st);
    end

    // Reset while entries are still queued and in flight.
    for (int i = 0; i < 4; i++)
      do_cmd("rst_push", 10'd0, $urandom(), $urandom(), r, st);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    acc_model = 0;
    off_model = 0;
    @(negedge clk);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_mid_rsp_data", bus.rsp_payload_outputs_0, 32'd0);
    @(posedge clk);
    #1;
    do_cmd("rst_drain", 10'd1, '0, '0, r, st);
    check("rst_drain_zero", r, 32'd0);
    do_cmd("rst_set_off", 10'd3, 32'd5, '0, r, st);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
